// File: rtl/jisp_pkg.sv
// Shared definitions for the JISP capture controller.
//   state_t               : controller FSM states
//   DRAIN_TIMEOUT_DEFAULT : default cycle budget from end of frame to pipe_done
package jisp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_SOF,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int unsigned DRAIN_TIMEOUT_DEFAULT = 32'd1 << 20;

endpackage

// File: rtl/jisp_ctrl_linecnt.sv
// Sensor strobe edge detection plus the line and drain counters of jisp_ctrl.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   frame_valid_in        : sensor frame strobe
//   line_valid_in         : sensor line strobe
//   line_clr / line_en    : clear / enable the line-end counter
//   drain_clr / drain_en  : clear / enable the drain cycle counter
//   fv_rise / fv_fall     : frame strobe edges (vs. registered previous sample)
//   lv_fall               : line strobe falling edge
//   line_cnt              : number of line ends counted while enabled
//   drain_cnt             : number of cycles counted while enabled
module jisp_ctrl_linecnt #(
    parameter int unsigned YW = 10,
    parameter int unsigned DW = 21
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_valid_in,
    input  logic          line_valid_in,
    input  logic          line_clr,
    input  logic          line_en,
    input  logic          drain_clr,
    input  logic          drain_en,
    output logic          fv_rise,
    output logic          fv_fall,
    output logic          lv_fall,
    output logic [YW:0]   line_cnt,
    output logic [DW-1:0] drain_cnt
);

    logic fv_q;
    logic lv_q;

    assign fv_rise = frame_valid_in & ~fv_q;
    assign fv_fall = ~frame_valid_in & fv_q;
    assign lv_fall = ~line_valid_in & lv_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fv_q      <= 1'b0;
            lv_q      <= 1'b0;
            line_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            fv_q <= frame_valid_in;
            lv_q <= line_valid_in;

            if (line_clr)
                line_cnt <= '0;
            else if (line_en && lv_fall)
                line_cnt <= line_cnt + (YW+1)'(1);

            if (drain_clr)
                drain_cnt <= '0;
            else if (drain_en)
                drain_cnt <= drain_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/jisp_ctrl.sv
// Capture controller sitting between the image sensor and rgb2yuv.
// Arms on start, waits for a clean start of frame, passes exactly one frame
// through the strobe gates, then waits for the encoder to drain.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   start / abort                 : capture request / cancel (single-cycle pulses)
//   x_size_m1_cfg / y_size_m1_cfg : requested frame size minus one
//   frame/line/rgb24_valid_in     : sensor strobes
//   pipe_done                     : encoder finished the last byte
//   frame/line/rgb24_valid_out    : gated strobes to the ISP
//   x_size_m1 / y_size_m1         : shadowed frame size to the ISP
//   busy / done / flush / error   : status (error is sticky)
module jisp_ctrl
    import jisp_pkg::*;
#(
    parameter int unsigned SENSOR_X_SIZE = 720,
    parameter int unsigned SENSOR_Y_SIZE = 720,
    parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEFAULT,
    localparam int unsigned XW = $clog2(SENSOR_X_SIZE),
    localparam int unsigned YW = $clog2(SENSOR_Y_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [XW-1:0] x_size_m1_cfg,
    input  logic [YW-1:0] y_size_m1_cfg,
    input  logic          frame_valid_in,
    input  logic          line_valid_in,
    input  logic          rgb24_valid_in,
    input  logic          pipe_done,
    output logic          frame_valid_out,
    output logic          line_valid_out,
    output logic          rgb24_valid_out,
    output logic [XW-1:0] x_size_m1,
    output logic [YW-1:0] y_size_m1,
    output logic          busy,
    output logic          done,
    output logic          flush,
    output logic          error
);

    localparam int unsigned DW = $clog2(DRAIN_TIMEOUT) + 1;

    state_t        state, state_next;
    logic          latch_cfg, err_set, err_clr, flush_next;
    logic          en;
    logic          fv_rise, fv_fall, lv_fall;
    logic [YW:0]   line_cnt, line_total, lines_exp;
    logic [DW-1:0] drain_cnt;

    jisp_ctrl_linecnt #(
        .YW (YW),
        .DW (DW)
    ) u_linecnt (
        .clk            (clk),
        .reset          (reset),
        .frame_valid_in (frame_valid_in),
        .line_valid_in  (line_valid_in),
        .line_clr       (state != ST_CAPTURE),
        .line_en        (state == ST_CAPTURE),
        .drain_clr      (state != ST_DRAIN),
        .drain_en       (state == ST_DRAIN),
        .fv_rise        (fv_rise),
        .fv_fall        (fv_fall),
        .lv_fall        (lv_fall),
        .line_cnt       (line_cnt),
        .drain_cnt      (drain_cnt)
    );

    // A line ending on the same cycle as the frame still counts.
    assign line_total = line_cnt + (YW+1)'(lv_fall);
    assign lines_exp  = {1'b0, y_size_m1} + (YW+1)'(1);

    // The SOF cycle itself is passed so the ISP sees the frame strobe rise.
    // Reset is folded in so the gates close without waiting for a clock.
    assign en = ~reset & ((state == ST_CAPTURE) | ((state == ST_WAIT_SOF) & fv_rise));

    assign frame_valid_out = frame_valid_in & en;
    assign line_valid_out  = line_valid_in  & en;
    assign rgb24_valid_out = rgb24_valid_in & en;
    assign busy            = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        latch_cfg  = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        flush_next = 1'b0;
        done       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (x_size_m1_cfg[0] && y_size_m1_cfg[0]) begin
                        latch_cfg  = 1'b1;
                        err_clr    = 1'b1;
                        state_next = ST_ARM;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (!frame_valid_in)
                    state_next = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (fv_rise)
                    state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (fv_fall) begin
                    state_next = ST_DRAIN;
                    if (line_total != lines_exp)
                        err_set = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (pipe_done) begin
                    state_next = ST_DONE;
                end else if (drain_cnt == DW'(DRAIN_TIMEOUT - 1)) begin
                    err_set    = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Abort overrides every other outcome outside IDLE.
        if (abort && state != ST_IDLE) begin
            state_next = ST_IDLE;
            flush_next = 1'b1;
            done       = 1'b0;
            err_set    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            x_size_m1 <= '1;
            y_size_m1 <= '1;
            error     <= 1'b0;
            flush     <= 1'b0;
        end else begin
            state <= state_next;
            flush <= flush_next;
            if (latch_cfg) begin
                x_size_m1 <= x_size_m1_cfg;
                y_size_m1 <= y_size_m1_cfg;
            end
            if (err_set)
                error <= 1'b1;
            else if (err_clr)
                error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jisp_ctrl.sv
// Self-checking bench for jisp_ctrl: start/config vector table plus
// hand-written frame, drain, abort and reset sequences.
module tb_jisp_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, abort, pipe_done;
    logic [9:0] xcfg, ycfg;
    logic       fv, lv, rgb;
    logic       fv_out, lv_out, rgb_out;
    logic [9:0] x_sh, y_sh;
    logic       busy, done, flush, error;

    int total = 0;
    int bad   = 0;

    int lv_pulses = 0, px = 0, done_cnt = 0, flush_cnt = 0;
    logic lvo_q = 1'b0;

    jisp_ctrl #(
        .SENSOR_X_SIZE (720),
        .SENSOR_Y_SIZE (720),
        .DRAIN_TIMEOUT (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .x_size_m1_cfg   (xcfg),
        .y_size_m1_cfg   (ycfg),
        .frame_valid_in  (fv),
        .line_valid_in   (lv),
        .rgb24_valid_in  (rgb),
        .pipe_done       (pipe_done),
        .frame_valid_out (fv_out),
        .line_valid_out  (lv_out),
        .rgb24_valid_out (rgb_out),
        .x_size_m1       (x_sh),
        .y_size_m1       (y_sh),
        .busy            (busy),
        .done            (done),
        .flush           (flush),
        .error           (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (lv_out && !lvo_q) lv_pulses++;
        lvo_q = lv_out;
        if (rgb_out) px++;
        if (done)    done_cnt++;
        if (flush)   flush_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       ab;
        logic [9:0] x;
        logic [9:0] y;
        logic       e_busy;
        logic       e_err;
        logic [9:0] e_x;
        logic [9:0] e_y;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic line_pulse();
        lv = 1'b1; rgb = 1'b1;
        tick(); tick();
        lv = 1'b0; rgb = 1'b0;
        tick(); tick();
    endtask

    // Drives a full frame and leaves frame_valid low right after a clock edge.
    task automatic frame(input int n);
        fv = 1'b1;
        tick(); tick();
        repeat (n) line_pulse();
        fv = 1'b0;
    endtask

    task automatic do_start(input logic [9:0] x, input logic [9:0] y);
        xcfg = x; ycfg = y; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic pulse_done();
        pipe_done = 1'b1;
        tick();
        pipe_done = 1'b0;
    endtask

    // Waits (bounded) for done; returns the loop index it was seen on, 0 if never.
    task automatic wait_done(output int seen_at, output int err_k3);
        seen_at = 0;
        err_k3  = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 3) err_k3 = int'(error);
            if (done) begin
                seen_at = k;
                break;
            end
        end
    endtask

    int b_lv, b_px, b_done, b_flush, seen, e3;

    initial begin
        vt[0] = '{1'b0, 10'd719, 10'd719, 1'b1, 1'b0, 10'd719, 10'd719};
        vt[1] = '{1'b0, 10'd718, 10'd719, 1'b0, 1'b1, 10'd719, 10'd719};
        vt[2] = '{1'b0, 10'd719, 10'd718, 1'b0, 1'b1, 10'd719, 10'd719};
        vt[3] = '{1'b1, 10'd101, 10'd3,   1'b0, 1'b1, 10'd719, 10'd719};
        vt[4] = '{1'b0, 10'd101, 10'd3,   1'b1, 1'b0, 10'd101, 10'd3};
        vt[5] = '{1'b0, 10'd4,   10'd5,   1'b0, 1'b1, 10'd101, 10'd3};

        // Reset with sensor strobes high: everything quiet, shadows all ones.
        reset = 1'b1; start = 1'b0; abort = 1'b0; pipe_done = 1'b0;
        xcfg = '0; ycfg = '0;
        fv = 1'b1; lv = 1'b1; rgb = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_fv_out",  int'(fv_out),  0);
        chk("rst_lv_out",  int'(lv_out),  0);
        chk("rst_rgb_out", int'(rgb_out), 0);
        chk("rst_busy",    int'(busy),    0);
        chk("rst_done",    int'(done),    0);
        chk("rst_flush",   int'(flush),   0);
        chk("rst_error",   int'(error),   0);
        chk("rst_x",       int'(x_sh),    1023);
        chk("rst_y",       int'(y_sh),    1023);
        fv = 1'b0; lv = 1'b0; rgb = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Start/config table in IDLE with the sensor idle.
        for (int i = 0; i < 6; i++) begin
            xcfg = vt[i].x; ycfg = vt[i].y;
            abort = vt[i].ab; start = 1'b1;
            tick();
            start = 1'b0; abort = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i),  int'(busy),  int'(vt[i].e_busy));
            chk($sformatf("vec%0d_error", i), int'(error), int'(vt[i].e_err));
            chk($sformatf("vec%0d_x", i),     int'(x_sh),  int'(vt[i].e_x));
            chk($sformatf("vec%0d_y", i),     int'(y_sh),  int'(vt[i].e_y));
            if (vt[i].e_busy) begin
                tick();
                do_abort();
                @(negedge clk);
                chk($sformatf("vec%0d_flush", i),      int'(flush), 1);
                chk($sformatf("vec%0d_busy_ab", i),    int'(busy),  0);
            end
            tick();
        end

        // Start mid-frame: the partial frame is blocked, the next full frame passes.
        fv = 1'b1;
        tick();
        b_lv = lv_pulses;
        do_start(10'd719, 10'd719);
        repeat (10) line_pulse();
        chk("full_partial_blocked", lv_pulses - b_lv, 0);
        chk("full_busy_arm", int'(busy), 1);
        fv = 1'b0;
        tick(); tick();
        b_lv = lv_pulses; b_px = px; b_done = done_cnt;
        frame(720);
        tick(); tick();
        chk("full_lines", lv_pulses - b_lv, 720);
        chk("full_pixels", px - b_px, 1440);
        chk("full_err_pre", int'(error), 0);
        chk("full_no_early_done", done_cnt - b_done, 0);
        pulse_done();
        wait_done(seen, e3);
        chk("full_done_seen", int'(seen != 0), 1);
        tick(); tick();
        chk("full_done_1cyc", done_cnt - b_done, 1);
        chk("full_busy_end", int'(busy), 0);
        chk("full_err_end", int'(error), 0);

        // Short sensor frame: error at frame end, done still follows pipe_done.
        do_start(10'd719, 10'd719);
        tick();
        b_done = done_cnt;
        frame(700);
        tick(); tick();
        chk("short_err", int'(error), 1);
        chk("short_busy", int'(busy), 1);
        pulse_done();
        wait_done(seen, e3);
        chk("short_done_seen", int'(seen != 0), 1);
        tick();
        chk("short_done_1cyc", done_cnt - b_done, 1);

        // Drain timeout: DRAIN entered one edge after frame end, done 16 cycles later.
        do_start(10'd719, 10'd3);
        tick();
        frame(4);
        wait_done(seen, e3);
        chk("tmo_err_early", e3, 0);
        chk("tmo_done_at", seen, 18);
        chk("tmo_err", int'(error), 1);
        @(negedge clk);
        chk("tmo_busy_after", int'(busy), 0);

        // Abort on the 100th captured line.
        do_start(10'd719, 10'd719);
        tick();
        b_lv = lv_pulses; b_done = done_cnt; b_flush = flush_cnt;
        fv = 1'b1;
        tick(); tick();
        repeat (99) line_pulse();
        lv = 1'b1; rgb = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk("ab_gate_still_open", int'(lv_out), 1);
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("ab_flush", int'(flush), 1);
        chk("ab_lv_closed", int'(lv_out), 0);
        chk("ab_rgb_closed", int'(rgb_out), 0);
        chk("ab_fv_closed", int'(fv_out), 0);
        chk("ab_busy", int'(busy), 0);
        tick();
        @(negedge clk);
        chk("ab_flush_1cyc", int'(flush), 0);
        lv = 1'b0; rgb = 1'b0;
        tick(); tick();
        repeat (20) line_pulse();
        fv = 1'b0;
        repeat (20) tick();
        chk("ab_lines", lv_pulses - b_lv, 100);
        chk("ab_no_done", done_cnt - b_done, 0);
        chk("ab_flush_cnt", flush_cnt - b_flush, 1);

        // Second start during CAPTURE is ignored; reset mid-line closes gates at once.
        do_start(10'd719, 10'd719);
        tick();
        fv = 1'b1;
        tick(); tick();
        repeat (5) line_pulse();
        xcfg = 10'd101; ycfg = 10'd3; start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("restart_x", int'(x_sh), 719);
        chk("restart_y", int'(y_sh), 719);
        chk("restart_busy", int'(busy), 1);
        chk("restart_err", int'(error), 0);
        lv = 1'b1; rgb = 1'b1;
        tick();
        @(negedge clk);
        chk("arst_open_before", int'(lv_out), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_lv", int'(lv_out), 0);
        chk("arst_fv", int'(fv_out), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_x", int'(x_sh), 1023);
        fv = 1'b0; lv = 1'b0; rgb = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jisp_ctrl.md
JISP_CTRL -- requirements
Module: jisp_ctrl

Interface
REQ-001 SHALL have parameter SENSOR_X_SIZE, default 720, max image width; XW = clog2(SENSOR_X_SIZE).
REQ-002 SHALL have parameter SENSOR_Y_SIZE, default 720, max image height; YW = clog2(SENSOR_Y_SIZE).
REQ-003 SHALL have parameter DRAIN_TIMEOUT, default 2^20, max cycles from end of frame to pipe_done.
REQ-004 Ports, in this order:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  capture request, single-cycle pulse
- abort  in  1  cancel request, single-cycle pulse
- x_size_m1_cfg  in  XW  requested width-1
- y_size_m1_cfg  in  YW  requested height-1
- frame_valid_in  in  1  sensor frame strobe
- line_valid_in  in  1  sensor line strobe
- rgb24_valid_in  in  1  sensor pixel valid
- pipe_done  in  1  encoder finished last byte, pulse
- frame_valid_out  out  1  gated frame strobe to ISP
- line_valid_out  out  1  gated line strobe
- rgb24_valid_out  out  1  gated pixel valid
- x_size_m1  out  XW  shadowed width-1 to ISP
- y_size_m1  out  YW  shadowed height-1 to ISP
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- flush  out  1  one-cycle downstream flush pulse
- error  out  1  sticky fault flag

Function
REQ-005 States: IDLE, ARM, WAIT_SOF, CAPTURE, DRAIN, DONE.
REQ-006 IDLE: start with x_size_m1_cfg[0]=1 and y_size_m1_cfg[0]=1 SHALL latch both cfg values into x_size_m1/y_size_m1, clear error, go to ARM.
REQ-007 IDLE: start with either cfg LSB 0 (odd dimension) SHALL set error, stay IDLE, leave shadows unchanged.
REQ-008 ARM: go to WAIT_SOF on the first cycle frame_valid_in=0; no partial frame is ever passed.
REQ-009 WAIT_SOF: on frame_valid_in=1 while its registered previous sample fv_q=0, go to CAPTURE.
REQ-010 Gate enable en = (state==CAPTURE) or (state==WAIT_SOF and frame_valid_in and not fv_q); each *_out = matching *_in AND en, combinational, zero latency.
REQ-011 CAPTURE: count line_valid_in falling edges in YW+1-bit counter, cleared on entry.
REQ-012 CAPTURE: on frame_valid_in falling edge go to DRAIN; if line count != y_size_m1+1, set error.
REQ-013 DRAIN: gates closed; count cycles from 0; pipe_done -> DONE; count reaching DRAIN_TIMEOUT-1 sets error and goes to DONE.
REQ-014 DONE: done=1 for exactly that cycle, then IDLE; start in DONE ignored.
REQ-015 start while busy SHALL be ignored.
REQ-016 abort in ARM/WAIT_SOF/CAPTURE/DRAIN/DONE: next state IDLE, flush=1 next cycle, gates close the cycle after abort; no done pulse.
REQ-017 abort and start same cycle in IDLE: abort wins, start ignored; abort in IDLE has no effect.
REQ-018 pipe_done outside DRAIN SHALL be ignored.
REQ-019 x_size_m1/y_size_m1 SHALL change only per REQ-006.
REQ-020 error SHALL clear only on accepted start or reset.

Reset
REQ-021 reset SHALL force IDLE, fv_q=0, all counters 0, x_size_m1/y_size_m1 = all ones, busy/done/flush/error = 0; gated outputs 0 while reset asserted.
REQ-022 Reset assertion mid-frame SHALL close gates asynchronously.

Structure
REQ-023 State enum and DRAIN_TIMEOUT default SHALL live in shared package jisp_pkg.
REQ-024 Edge detect plus counters SHALL be one sub-module, jisp_ctrl_linecnt; jisp_ctrl instantiates it between the sensor and rgb2yuv.

Verification
REQ-025 cfg 719/719, start mid-frame -> ARM, first full frame passed with 720 line_valid pulses, pipe_done -> done 1 cycle, error=0.
REQ-026 cfg 718/719, start -> error=1, busy=0, shadows stay 719/719.
REQ-027 cfg 719/719, sensor frame of 700 lines -> error=1 at frame end, done still pulses after pipe_done.
REQ-028 DRAIN_TIMEOUT=16, no pipe_done -> done exactly 16 cycles after DRAIN entry, error=1.
REQ-029 abort on 100th CAPTURE line -> flush 1 cycle, outputs low from next cycle, busy=0, no done.
REQ-030 start and abort same cycle in IDLE -> stays IDLE; second start during CAPTURE -> ignored, shadows unchanged.
